pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/hz_pkg.sv | 24 ++
 rtl/ld_use_detect.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/hz_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : controller FSM states
//   OP_*       : RV32 major opcodes that read source registers
//   STALL_MAX  : saturation value for the stall counter
package hz_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } hz_state_t;

    // Opcodes that read both rs1 and rs2
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    // Opcodes that read rs1 only
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/ld_use_detect.sv
// Combinational load-use hazard detector.
// Ports:
//   id_instr    (in, 32) instruction in ID
//   ex_mem_read (in, 1)  EX instruction is a load
//   ex_rd       (in, 5)  destination register of the EX instruction
//   hazard      (out, 1) the ID instruction reads the register the load writes
module ld_use_detect
    import hz_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       unused_bits;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // rd/funct fields play no role in source matching
    assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

    // Field positions are only meaningful for formats that really carry
    // rs1/rs2; U/J-type bits in those positions must not match.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_S, OP_B: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I, OP_LD, OP_JALR: begin
                use_rs1 = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 is never a real dependency
    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle MUL/DIV freeze,
// and branch flushes for a 5-stage pipeline.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   id_instr (32)               instruction in ID
//   ex_mem_read, ex_rd (5)      load in EX and its destination
//   ex_is_md, md_done           MUL/DIV in EX, MUL/DIV result-ready pulse
//   br_taken_ex                 branch/jump resolved taken in EX
//   pc_we, if_id_we, id_ex_we   pipeline register write enables
//   id_ex_bubble, ex_mem_bubble zero control entering ID/EX, EX/MEM
//   if_id_flush, id_ex_flush    clear IF/ID, ID/EX
//   md_start                    one-cycle MUL/DIV start pulse
//   stall_cycles (16)           saturating count of cycles with pc_we=0
module pipe_hazard_ctrl
    import hz_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_md,
    input  logic        md_done,
    input  logic        br_taken_ex,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_start,
    output logic [15:0] stall_cycles
);

    hz_state_t   state_reg;
    hz_state_t   state_next;
    logic [15:0] stall_cnt_reg;
    logic        ld_hazard;

    ld_use_detect u_ld_use_detect (
        .id_instr    (id_instr),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (ld_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        md_start      = 1'b0;

        case (state_reg)
            RUN, MD_DONE: begin
                // A taken branch discards ID and IF, so any stall on the
                // younger instructions would be pointless.
                if (br_taken_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if ((state_reg == RUN) && ex_is_md) begin
                    // The MUL/DIV still sitting in EX during MD_DONE has
                    // already run; only RUN may launch a new operation.
                    md_start      = 1'b1;
                    pc_we         = 1'b0;
                    if_id_we      = 1'b0;
                    id_ex_we      = 1'b0;
                    ex_mem_bubble = 1'b1;
                    state_next    = MD_BUSY;
                end else if (ld_hazard) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                if (state_reg == MD_DONE) begin
                    state_next = RUN;
                end
            end
            MD_BUSY: begin
                pc_we         = 1'b0;
                if_id_we      = 1'b0;
                id_ex_we      = 1'b0;
                ex_mem_bubble = 1'b1;
                if (md_done) begin
                    state_next = MD_DONE;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 16'd0;
        end else if (!pc_we && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;

endmodule
